// File: rtl/mmio_port.sv
// mmio_port: memory-mapped byte I/O port responding on a two-byte window.
//   BASE_ADDR   : DATA   (read pops RX FIFO, write pushes TX FIFO)
//   BASE_ADDR+1 : STATUS (read {0000, rx_full, tx_overflow, tx_not_full, rx_nonempty};
//                         write with bit 2 set clears tx_overflow)
// Ports:
//   CLK, RST_bar                 clock, async active-low reset
//   ADDR_IN, DATA_IN             processor address / write data
//   WE_bar, OE_bar               processor write strobe / read enable (active-low)
//   DATA_OUT, ASSERT_bar         read data, low while this block drives the bus
//   RX_DATA, RX_VALID, RX_READY  device -> processor byte stream
//   TX_DATA, TX_VALID, TX_READY  processor -> device byte stream
// DELAY_RISE/DELAY_FALL describe the bus-facing output delays of the modelled
// part; the synthesized outputs carry no delay of their own.

module mmio_fifo #(
    parameter int DEPTH_LOG2 = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] wdata,
    output logic [7:0] head,
    output logic       nonempty,
    output logic       full
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;
    localparam logic [DEPTH_LOG2:0]   CNT_ONE = 1;
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wp;
    logic [DEPTH_LOG2-1:0] rp;
    logic [DEPTH_LOG2:0]   count;
    logic                  do_push;
    logic                  do_pop;

    assign nonempty = (count != '0);
    assign full     = (count == CNT_FULL);
    // Both gates use the pre-edge count: a push into an empty FIFO cannot be
    // popped on the same edge, and a pop does not make room for a same-edge push.
    assign do_push  = push & ~full;
    assign do_pop   = pop & nonempty;
    assign head     = nonempty ? mem[rp] : 8'h00;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wp] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wp <= wp + PTR_ONE;
            end
            if (do_pop) begin
                rp <= rp + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end
endmodule

module mmio_port #(
    parameter int          DELAY_RISE = 0,
    parameter int          DELAY_FALL = 0,
    parameter logic [15:0] BASE_ADDR  = 16'hFF00,
    parameter int          DEPTH_LOG2 = 2
) (
    input  logic        CLK,
    input  logic        RST_bar,
    input  logic [15:0] ADDR_IN,
    input  logic [7:0]  DATA_IN,
    input  logic        WE_bar,
    input  logic        OE_bar,
    output logic [7:0]  DATA_OUT,
    output logic        ASSERT_bar,
    input  logic [7:0]  RX_DATA,
    input  logic        RX_VALID,
    output logic        RX_READY,
    output logic [7:0]  TX_DATA,
    output logic        TX_VALID,
    input  logic        TX_READY
);
    if (DELAY_RISE < 0 || DELAY_FALL < 0 || DEPTH_LOG2 < 1 || DEPTH_LOG2 > 4) begin : g_bad_params
        $error("mmio_port: delays must be >= 0 and DEPTH_LOG2 in 1..4");
    end

    logic       sel;
    logic       rd_act;
    logic       wr_act;
    logic       rd_data;
    logic       wr_data;
    logic       wr_status;
    logic [2:0] hist;
    logic       fire_rd_data;
    logic       fire_wr_data;
    logic       fire_wr_status;

    logic [7:0] rx_head;
    logic       rx_nonempty;
    logic       rx_full;
    logic       rx_push;
    logic       rx_pop;

    logic [7:0] tx_head;
    logic       tx_nonempty;
    logic       tx_full;
    logic       tx_push;
    logic       tx_pop;
    logic       tx_overflow;

    logic [7:0] status;

    assign sel       = (ADDR_IN[15:1] == BASE_ADDR[15:1]);
    assign rd_act    = sel & ~OE_bar & WE_bar;
    assign wr_act    = sel & ~WE_bar;
    assign rd_data   = rd_act & ~ADDR_IN[0];
    assign wr_data   = wr_act & ~ADDR_IN[0];
    assign wr_status = wr_act &  ADDR_IN[0];

    // Side effects fire only on the first edge of a contiguous access; hist
    // remembers what was active at the previous edge.
    assign fire_rd_data   = rd_data   & ~hist[2];
    assign fire_wr_data   = wr_data   & ~hist[1];
    assign fire_wr_status = wr_status & ~hist[0];

    always_ff @(posedge CLK or negedge RST_bar) begin
        if (!RST_bar) begin
            hist <= 3'b000;
        end else begin
            hist <= {rd_data, wr_data, wr_status};
        end
    end

    assign rx_push = RX_VALID & ~rx_full;
    assign rx_pop  = fire_rd_data;
    assign tx_push = fire_wr_data;
    assign tx_pop  = TX_READY;

    mmio_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
        .clk      (CLK),
        .rst_n    (RST_bar),
        .push     (rx_push),
        .pop      (rx_pop),
        .wdata    (RX_DATA),
        .head     (rx_head),
        .nonempty (rx_nonempty),
        .full     (rx_full)
    );

    mmio_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
        .clk      (CLK),
        .rst_n    (RST_bar),
        .push     (tx_push),
        .pop      (tx_pop),
        .wdata    (DATA_IN),
        .head     (tx_head),
        .nonempty (tx_nonempty),
        .full     (tx_full)
    );

    // A write to a full TX FIFO is dropped and flagged; fullness is judged
    // before any same-edge device pop.
    always_ff @(posedge CLK or negedge RST_bar) begin
        if (!RST_bar) begin
            tx_overflow <= 1'b0;
        end else if (fire_wr_data && tx_full) begin
            tx_overflow <= 1'b1;
        end else if (fire_wr_status && DATA_IN[2]) begin
            tx_overflow <= 1'b0;
        end
    end

    assign status = {4'b0000, rx_full, tx_overflow, ~tx_full, rx_nonempty};

    always_comb begin
        DATA_OUT   = 8'h00;
        ASSERT_bar = 1'b1;
        if (rd_act) begin
            ASSERT_bar = 1'b0;
            DATA_OUT   = ADDR_IN[0] ? status : rx_head;
        end
    end

    assign RX_READY = ~rx_full;
    assign TX_VALID = tx_nonempty;
    assign TX_DATA  = tx_head;
endmodule
